// File: rtl/seq_sum_monitor.sv
// Running-sum monitor: tracks step count, last delta, peak, threshold and sticky wrap flag of Q.
// Latency: one cycle; every output reflects the sample taken at the previous enabled edge.
// Backpressure: none; i_en=0 holds every register and the upstream sum is simply not sampled.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset
//   i_q_in       running sum from the sequence adder (WIDTH)
//   i_en         sample enable, 0 = hold everything
//   i_clr        synchronous soft clear, same effect as i_rst
//   o_step_cnt   number of observed sum changes, saturating (CNT_W)
//   o_delta      i_q_in minus previous sample, modulo 2^WIDTH
//   o_peak       largest sample since reset/clear (unsigned)
//   o_thresh_hit last sample >= THRESH (unsigned)
//   o_ovf        sticky: a decrease (wrap) of the sum was observed
//   o_state      00 IDLE, 01 TRACK, 10 WRAPPED
module seq_sum_monitor #(
  parameter int                 WIDTH  = 8,
  parameter int                 CNT_W  = 8,
  parameter logic [WIDTH-1:0]   THRESH = 8'd100
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_q_in,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_step_cnt,
  output logic [WIDTH-1:0] o_delta,
  output logic [WIDTH-1:0] o_peak,
  output logic             o_thresh_hit,
  output logic             o_ovf,
  output logic [1:0]       o_state
);

  // S_BAD is listed so the decoder covers all encodings explicitly.
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_TRACK   = 2'b01,
    S_WRAPPED = 2'b10,
    S_BAD     = 2'b11
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_step_cnt;
  logic [WIDTH-1:0] r_delta;
  logic [WIDTH-1:0] r_peak;
  logic             r_thresh_hit;
  logic             r_ovf;

  state_t           w_nxt_state;
  logic [WIDTH-1:0] w_nxt_prev;
  logic [CNT_W-1:0] w_nxt_step_cnt;
  logic [WIDTH-1:0] w_nxt_delta;
  logic [WIDTH-1:0] w_nxt_peak;
  logic             w_nxt_thresh_hit;
  logic             w_nxt_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_prev       <= '0;
      r_step_cnt   <= '0;
      r_delta      <= '0;
      r_peak       <= '0;
      r_thresh_hit <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_prev       <= w_nxt_prev;
      r_step_cnt   <= w_nxt_step_cnt;
      r_delta      <= w_nxt_delta;
      r_peak       <= w_nxt_peak;
      r_thresh_hit <= w_nxt_thresh_hit;
      r_ovf        <= w_nxt_ovf;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_prev       = r_prev;
    w_nxt_step_cnt   = r_step_cnt;
    w_nxt_delta      = r_delta;
    w_nxt_peak       = r_peak;
    w_nxt_thresh_hit = r_thresh_hit;
    w_nxt_ovf        = r_ovf;

    // Soft clear and the illegal encoding both fall back to a full clear;
    // the simultaneous sample, if any, is discarded.
    if (i_clr || (r_state == S_BAD)) begin
      w_nxt_state      = S_IDLE;
      w_nxt_prev       = '0;
      w_nxt_step_cnt   = '0;
      w_nxt_delta      = '0;
      w_nxt_peak       = '0;
      w_nxt_thresh_hit = 1'b0;
      w_nxt_ovf        = 1'b0;
    end else if (i_en) begin
      w_nxt_prev       = i_q_in;
      w_nxt_thresh_hit = (i_q_in >= THRESH);
      case (r_state)
        S_IDLE: begin
          // First sample only seeds history; no step or delta yet.
          w_nxt_peak  = i_q_in;
          w_nxt_state = S_TRACK;
        end
        default: begin
          // TRACK and WRAPPED share the datapath; WRAPPED is only left by clear.
          w_nxt_peak = (i_q_in > r_peak) ? i_q_in : r_peak;
          if (i_q_in != r_prev) begin
            w_nxt_delta    = i_q_in - r_prev;
            w_nxt_step_cnt = (r_step_cnt == {CNT_W{1'b1}}) ? r_step_cnt
                                                           : r_step_cnt + 1'b1;
          end else begin
            w_nxt_delta = '0;
          end
          if (i_q_in < r_prev) begin
            w_nxt_ovf   = 1'b1;
            w_nxt_state = S_WRAPPED;
          end
        end
      endcase
    end
  end

  assign o_step_cnt   = r_step_cnt;
  assign o_delta      = r_delta;
  assign o_peak       = r_peak;
  assign o_thresh_hit = r_thresh_hit;
  assign o_ovf        = r_ovf;
  assign o_state      = r_state;

endmodule

// File: tb/tb_seq_sum_monitor.sv
// Directed bench for seq_sum_monitor: hand-computed vectors on a default
// instance plus a CNT_W=2 instance for step-counter saturation.
module tb_seq_sum_monitor;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [7:0] q;
  logic [7:0] step_cnt, delta, peak;
  logic       thresh_hit, ovf;
  logic [1:0] state;

  logic       s_rst, s_en, s_clr;
  logic [7:0] s_q;
  logic [1:0] s_step_cnt;
  logic [7:0] s_delta, s_peak;
  logic       s_thresh_hit, s_ovf;
  logic [1:0] s_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_sum_monitor dut (
    .i_clk(clk), .i_rst(rst), .i_q_in(q), .i_en(en), .i_clr(clr),
    .o_step_cnt(step_cnt), .o_delta(delta), .o_peak(peak),
    .o_thresh_hit(thresh_hit), .o_ovf(ovf), .o_state(state)
  );

  seq_sum_monitor #(.WIDTH(8), .CNT_W(2), .THRESH(8'd100)) dut_sat (
    .i_clk(clk), .i_rst(s_rst), .i_q_in(s_q), .i_en(s_en), .i_clr(s_clr),
    .o_step_cnt(s_step_cnt), .o_delta(s_delta), .o_peak(s_peak),
    .o_thresh_hit(s_thresh_hit), .o_ovf(s_ovf), .o_state(s_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_step, input int e_delta,
                         input int e_peak, input int e_th, input int e_ovf,
                         input int e_state);
    chk({tag, ".step"},   32'(step_cnt),   32'(e_step));
    chk({tag, ".delta"},  32'(delta),      32'(e_delta));
    chk({tag, ".peak"},   32'(peak),       32'(e_peak));
    chk({tag, ".thresh"}, 32'(thresh_hit), 32'(e_th));
    chk({tag, ".ovf"},    32'(ovf),        32'(e_ovf));
    chk({tag, ".state"},  32'(state),      32'(e_state));
  endtask

  // Apply one set of inputs across one rising edge, then settle past it.
  task automatic tick(input logic r, input logic c, input logic e, input logic [7:0] v);
    rst = r; clr = c; en = e; q = v;
    @(posedge clk);
    #1;
  endtask

  task automatic stick(input logic r, input logic e, input logic [7:0] v);
    s_rst = r; s_en = e; s_q = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ramp [5];
    ramp[0] = 8'd1; ramp[1] = 8'd3; ramp[2] = 8'd7; ramp[3] = 8'd15; ramp[4] = 8'd31;
    rst = 1'b1; clr = 1'b0; en = 1'b1; q = 8'h55;
    s_rst = 1'b1; s_clr = 1'b0; s_en = 1'b0; s_q = 8'h00;

    // Reset held two edges while EN and a nonzero Q are presented.
    tick(1'b1, 1'b0, 1'b1, 8'h55);
    tick(1'b1, 1'b0, 1'b1, 8'h55);
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // Ramp 1,3,7,15,31: first sample seeds, then four changes.
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, ramp[i]);
    chk_all("ramp", 4, 16, 31, 0, 0, 1);

    tick(1'b0, 1'b0, 1'b1, 8'd100);
    chk_all("thresh100", 5, 69, 100, 1, 0, 1);
    tick(1'b0, 1'b0, 1'b1, 8'd100);
    chk_all("repeat100", 5, 0, 100, 1, 0, 1);

    tick(1'b0, 1'b0, 1'b1, 8'hF0);
    chk_all("toF0", 6, 8'h8C, 8'hF0, 1, 0, 1);
    tick(1'b0, 1'b0, 1'b1, 8'h10);
    chk_all("wrap", 7, 8'h20, 8'hF0, 0, 1, 2);
    tick(1'b0, 1'b0, 1'b1, 8'h20);
    chk_all("afterwrap", 8, 8'h10, 8'hF0, 0, 1, 2);

    // Disabled: Q toggles but nothing moves.
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, 1'b0, (i % 2 == 0) ? 8'h00 : 8'hFF);
      if (i == 2) chk_all("hold_mid", 8, 8'h10, 8'hF0, 0, 1, 2);
    end
    chk_all("hold_end", 8, 8'h10, 8'hF0, 0, 1, 2);

    // Clear wins over a simultaneous sample.
    tick(1'b0, 1'b1, 1'b1, 8'h07);
    chk_all("clr", 0, 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 8'hC8);
    chk_all("first_after_clr", 0, 0, 8'hC8, 1, 0, 1);

    // Reset mid-operation discards the sample; next edge seeds again.
    tick(1'b1, 1'b0, 1'b1, 8'h33);
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    tick(1'b0, 1'b0, 1'b1, 8'h05);
    chk_all("first_after_rst", 0, 0, 5, 0, 0, 1);
    tick(1'b0, 1'b0, 1'b1, 8'h03);
    chk_all("small_wrap", 1, 8'hFE, 5, 0, 1, 2);

    // Narrow counter: saturates at 3 and never wraps back.
    stick(1'b0, 1'b1, 8'd10);
    chk("sat.seed", 32'(s_step_cnt), 32'd0);
    stick(1'b0, 1'b1, 8'd20);
    stick(1'b0, 1'b1, 8'd30);
    chk("sat.two", 32'(s_step_cnt), 32'd2);
    stick(1'b0, 1'b1, 8'd40);
    chk("sat.three", 32'(s_step_cnt), 32'd3);
    stick(1'b0, 1'b1, 8'd50);
    chk("sat.four", 32'(s_step_cnt), 32'd3);
    stick(1'b0, 1'b1, 8'd60);
    chk("sat.five", 32'(s_step_cnt), 32'd3);
    chk("sat.delta", 32'(s_delta), 32'd10);
    chk("sat.peak", 32'(s_peak), 32'd60);
    chk("sat.state", 32'(s_state), 32'd1);
    chk("sat.ovf", 32'(s_ovf), 32'd0);
    chk("sat.thresh", 32'(s_thresh_hit), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
